// File: rtl/data_memory_pkg.sv
// Shared types and sizing helpers for the pipelined data memory.
package data_memory_pkg;

  localparam int MAX_DATA_W = 64;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  // Byte-offset bits inside one word.
  function automatic int off_bits(input int data_w);
    return clog2(data_w / 8);
  endfunction

  function automatic int wa_bits(input int depth);
    return clog2(depth);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] count);
    return (count == 16'hFFFF) ? count : count + 16'd1;
  endfunction

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fsm_t;

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [MAX_DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/data_memory_lat_pipe.sv
// Delays a response by STAGES cycles; only the valid bits are reset.
module data_memory_lat_pipe
  import data_memory_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  resp_t head,
  output resp_t tail
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign tail = head;
  end else begin : g_stages
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     err_q;
    logic [MAX_DATA_W-1:0] rdata_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= head.valid;
        for (int s = 1; s < STAGES; s++) valid_q[s] <= valid_q[s-1];
      end
    end

    // Payload is qualified by valid downstream, so it carries no reset.
    always_ff @(posedge clk) begin
      err_q[0]   <= head.err;
      rdata_q[0] <= head.rdata;
      for (int s = 1; s < STAGES; s++) begin
        err_q[s]   <= err_q[s-1];
        rdata_q[s] <= rdata_q[s-1];
      end
    end

    assign tail = '{valid: valid_q[STAGES-1], err: err_q[STAGES-1], rdata: rdata_q[STAGES-1]};
  end

endmodule

// File: rtl/data_memory_pipe.sv
// Pipelined byte-enabled data memory with post-reset clear and error responses.
// Define DATA_MEMORY_STATS_EN to add the stat_rd/stat_wr/stat_err counters.
module data_memory_pipe
  import data_memory_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                busy
`ifdef DATA_MEMORY_STATS_EN
  ,
  output logic [15:0]         stat_rd,
  output logic [15:0]         stat_wr,
  output logic [15:0]         stat_err
`endif
);

  localparam int BE_W = DATA_W / 8;
  localparam int OFF  = off_bits(DATA_W);
  localparam int WA_W = wa_bits(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFF) - 1);

  fsm_t            state, state_next;
  logic [WA_W-1:0] clr_ptr, clr_ptr_next;

  logic            accept;
  logic            misaligned;
  logic            out_of_range;
  logic            req_err;
  logic [WA_W-1:0] word_idx;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  s0_valid;
  logic                  s0_err;
  logic [MAX_DATA_W-1:0] s0_rdata;
  resp_t                 s0;
  resp_t                 tail;
  logic                  unused_tail;

  assign accept       = req_valid && req_ready;
  assign misaligned   = (req_addr & ALIGN_MASK) != '0;
  assign out_of_range = (req_addr >> (OFF + WA_W)) != '0;
  assign req_err      = misaligned || out_of_range;
  assign word_idx     = WA_W'(req_addr >> OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // CLEAR walks every word once, then RUN holds until the next reset.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    busy         = 1'b0;
    req_ready    = 1'b0;
    case (state)
      CLEAR: begin
        busy         = 1'b1;
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == WA_W'(DEPTH - 1)) state_next = RUN;
      end
      RUN: req_ready = 1'b1;
    endcase
  end

  // Array and first response stage share one process so the read is a true
  // registered read; a write lands before any later read samples the word.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (accept && req_write && !req_err) begin
      for (int k = 0; k < BE_W; k++) begin
        if (req_be[k]) mem[word_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
    s0_err   <= req_err;
    s0_rdata <= '0;
    if (accept && !req_write && !req_err) s0_rdata <= MAX_DATA_W'(mem[word_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s0_valid <= 1'b0;
    else        s0_valid <= accept;
  end

  assign s0 = '{valid: s0_valid, err: s0_err, rdata: s0_rdata};

  data_memory_lat_pipe #(
    .STAGES(READ_LAT - 1)
  ) u_lat_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .head (s0),
    .tail (tail)
  );

  // Gating by valid keeps the outputs at zero out of reset without resetting data.
  assign resp_valid  = tail.valid;
  assign resp_err    = tail.valid & tail.err;
  assign resp_rdata  = tail.valid ? tail.rdata[DATA_W-1:0] : '0;
  assign unused_tail = ^tail.rdata;

`ifdef DATA_MEMORY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else if (accept) begin
      if (req_err)        stat_err <= sat_inc(stat_err);
      else if (req_write) stat_wr  <= sat_inc(stat_wr);
      else                stat_rd  <= sat_inc(stat_rd);
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_pipe.sv
// Randomized self-checking bench for data_memory_pipe against a byte-addressed model.
module tb_data_memory_pipe;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 256;
  localparam int READ_LAT = 3;
  localparam int BE_W     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [BE_W-1:0]   req_be = '0;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;
`ifdef DATA_MEMORY_STATS_EN
  logic [15:0]       stat_rd, stat_wr, stat_err;
  int                n_rd, n_wr, n_err;
`endif

  data_memory_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
`ifdef DATA_MEMORY_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          err;
    logic [15:0] rdata;
    bit          has_lit;
    bit          lit_err;
    logic [15:0] lit;
  } exp_t;

  logic [7:0] model_mem [DEPTH*BE_W];
  exp_t       exp_q[$];
  int         cyc = 0;
  int         rel_cyc = 0;
  bit         in_reset = 1'b1;
  int         checks = 0;
  int         errors = 0;

  function automatic bit model_ready();
    return !in_reset && ((cyc - rel_cyc) >= DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic checkOutput();
    exp_t e;
    bit   due;
    check("req_ready", req_ready, model_ready());
    check("busy", busy, !model_ready());
    due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("resp_valid", resp_valid, due);
    if (due) begin
      e = exp_q.pop_front();
      check("resp_err", resp_err, e.err);
      check("resp_rdata", resp_rdata, e.rdata);
      if (e.has_lit) begin
        check("model_rdata_pin", e.rdata, e.lit);
        check("model_err_pin", e.err, e.lit_err);
      end
    end
    if (in_reset) begin
      check("rdata_in_reset", resp_rdata, 0);
      check("err_in_reset", resp_err, 0);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #2;
    checkOutput();
  end

  task automatic applyStimulus(input bit write, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [1:0] be, input bit has_lit, input bit lit_err,
                               input logic [15:0] lit);
    exp_t        e;
    bit          err;
    logic [15:0] rd;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (model_ready()) begin
      err = (addr % BE_W) != 0 || int'(addr) >= DEPTH * BE_W;
      rd  = '0;
      if (!err) begin
        if (write) begin
          for (int k = 0; k < BE_W; k++)
            if (be[k]) model_mem[int'(addr) + k] = wdata[8*k +: 8];
        end else begin
          rd = {model_mem[int'(addr) + 1], model_mem[int'(addr)]};
        end
      end
`ifdef DATA_MEMORY_STATS_EN
      if (err) n_err++; else if (write) n_wr++; else n_rd++;
`endif
      e.due     = cyc + READ_LAT;
      e.err     = err;
      e.rdata   = rd;
      e.has_lit = has_lit;
      e.lit_err = lit_err;
      e.lit     = lit;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic resetDut(input int hold);
    @(negedge clk);
    rst_n     = 1'b0;
    in_reset  = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    #1;
    check("busy_at_reset", busy, 1);
    check("ready_at_reset", req_ready, 0);
    check("valid_at_reset", resp_valid, 0);
`ifdef DATA_MEMORY_STATS_EN
    n_rd = 0; n_wr = 0; n_err = 0;
    check("stat_rd_reset", stat_rd, 0);
    check("stat_wr_reset", stat_wr, 0);
    check("stat_err_reset", stat_err, 0);
`endif
    repeat (hold) @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    rel_cyc  = cyc;
  endtask

  task automatic waitReady();
    while (!req_ready && (cyc - rel_cyc) < 2 * DEPTH) @(negedge clk);
    check("clear_len", cyc - rel_cyc, DEPTH);
  endtask

  initial begin
    logic [15:0] addr;
    int          w;
    #1 rst_n = 1'b0;
    resetDut(3);

    // Requests during CLEAR must be ignored.
    idle(5);
    applyStimulus(1'b1, 16'h0004, 16'hDEAD, 2'b11, 0, 0, 16'h0);
    applyStimulus(1'b0, 16'h0004, 16'h0000, 2'b00, 0, 0, 16'h0);
    idle(1);
    waitReady();

    applyStimulus(1'b0, 16'h0000, 16'h0, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h00FE, 16'h0, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h01FE, 16'h0, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h0004, 16'h0, 2'b00, 1, 0, 16'h0000);

    applyStimulus(1'b1, 16'h0010, 16'hABCD, 2'b11, 1, 0, 16'h0000);
    applyStimulus(1'b1, 16'h0010, 16'h1234, 2'b01, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h0010, 16'h0, 2'b00, 1, 0, 16'hAB34);
    applyStimulus(1'b1, 16'h0012, 16'hFFFF, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h0012, 16'h0, 2'b00, 1, 0, 16'h0000);
    idle(2);

    applyStimulus(1'b1, 16'h0014, 16'h7788, 2'b11, 0, 0, 16'h0);
    idle(1);
    applyStimulus(1'b0, 16'h0010, 16'h0, 2'b00, 1, 0, 16'hAB34);
    applyStimulus(1'b0, 16'h0014, 16'h0, 2'b00, 1, 0, 16'h7788);
    applyStimulus(1'b0, 16'h0012, 16'h0, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h0010, 16'h0, 2'b00, 1, 0, 16'hAB34);

    applyStimulus(1'b1, 16'h0020, 16'h5A5A, 2'b11, 0, 0, 16'h0);
    applyStimulus(1'b0, 16'h0020, 16'h0, 2'b00, 1, 0, 16'h5A5A);

    applyStimulus(1'b0, 16'h0011, 16'h0, 2'b00, 1, 1, 16'h0000);
    applyStimulus(1'b1, 16'h0200, 16'hFFFF, 2'b11, 1, 1, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 16'h0, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b1, 16'h0021, 16'hFFFF, 2'b11, 1, 1, 16'h0000);
    applyStimulus(1'b0, 16'h0020, 16'h0, 2'b00, 1, 0, 16'h5A5A);
    idle(READ_LAT + 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        w    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 271)) : int'($urandom_range(0, 15));
        addr = 16'(2 * w + (($urandom_range(0, 7) == 0) ? 1 : 0));
        applyStimulus(1'($urandom_range(0, 1)), addr, 16'($urandom), 2'($urandom), 0, 0, 16'h0);
      end
    end
    idle(READ_LAT + 2);

`ifdef DATA_MEMORY_STATS_EN
    check("stat_rd", stat_rd, n_rd);
    check("stat_wr", stat_wr, n_wr);
    check("stat_err", stat_err, n_err);
`endif

    // Reset with two reads in flight: both responses must vanish.
    applyStimulus(1'b0, 16'h0020, 16'h0, 2'b00, 0, 0, 16'h0);
    applyStimulus(1'b0, 16'h0010, 16'h0, 2'b00, 0, 0, 16'h0);
    resetDut(2);
    idle(1);
    waitReady();
    applyStimulus(1'b0, 16'h0020, 16'h0, 2'b00, 1, 0, 16'h0000);
    applyStimulus(1'b0, 16'h0010, 16'h0, 2'b00, 1, 0, 16'h0000);
    idle(READ_LAT + 3);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
